// File: rtl/vx_sfu_router.sv
// SFU request router: steers requests to one of NUM_UNITS sub-units with per-unit
// credit limits, and merges sub-unit responses round-robin into one registered output.

module vx_sfu_router_unit #(
  parameter int MAX_PENDING   = 4,
  parameter int PW            = 3,
  parameter int PERF_CTR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_fire,
  input  logic                     rsp_fire,
  input  logic                     stall,
  output logic                     can_accept,
  output logic [PW-1:0]            pending,
  output logic [PERF_CTR_BITS-1:0] stall_cnt
);
  assign can_accept = pending < PW'(MAX_PENDING);

  // Simultaneous request and response fire leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      stall_cnt <= '0;
    end else begin
      if (req_fire && !rsp_fire && can_accept)
        pending <= pending + 1'b1;
      else if (rsp_fire && !req_fire && pending != '0)
        pending <= pending - 1'b1;
      if (stall)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

module vx_sfu_router #(
  parameter int NUM_UNITS     = 4,
  parameter int REQ_DATAW     = 64,
  parameter int RSP_DATAW     = 64,
  parameter int MAX_PENDING   = 4,
  parameter int PERF_CTR_BITS = 16,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [UW-1:0]                            req_unit,
  input  logic [REQ_DATAW-1:0]                     req_data,
  output logic [NUM_UNITS-1:0]                     unit_req_valid,
  input  logic [NUM_UNITS-1:0]                     unit_req_ready,
  output logic [REQ_DATAW-1:0]                     unit_req_data,
  input  logic [NUM_UNITS-1:0]                     unit_rsp_valid,
  output logic [NUM_UNITS-1:0]                     unit_rsp_ready,
  input  logic [NUM_UNITS-1:0][RSP_DATAW-1:0]      unit_rsp_data,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [RSP_DATAW-1:0]                     rsp_data,
  output logic [UW-1:0]                            rsp_sel,
  output logic [NUM_UNITS-1:0][PW-1:0]             pending,
  output logic                                     idle,
  output logic                                     err_unit,
  output logic [NUM_UNITS-1:0][PERF_CTR_BITS-1:0]  stall_cnt
);
  logic [NUM_UNITS-1:0] hit, can_acc, req_fire, rsp_fire, stall;
  logic                 in_range, load, gnt_any;
  logic [UW-1:0]        gnt_idx, ptr;
  logic [RSP_DATAW-1:0] gnt_data;

  assign unit_req_data = req_data;
  assign in_range      = |hit;
  // Out-of-range targets are accepted and dropped so the issue stage never deadlocks.
  assign req_ready     = in_range ? |(hit & unit_req_ready & can_acc) : 1'b1;
  assign load          = !rsp_valid || rsp_ready;
  assign idle          = (pending == '0) && !rsp_valid;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign hit[i]            = (req_unit == UW'(i));
    assign unit_req_valid[i] = req_valid && !reset && hit[i] && can_acc[i];
    assign req_fire[i]       = unit_req_valid[i] && unit_req_ready[i];
    assign rsp_fire[i]       = unit_rsp_valid[i] && unit_rsp_ready[i];
    assign stall[i]          = req_valid && hit[i] && !req_ready;

    vx_sfu_router_unit #(
      .MAX_PENDING  (MAX_PENDING),
      .PW           (PW),
      .PERF_CTR_BITS(PERF_CTR_BITS)
    ) u_unit (
      .clk       (clk),
      .reset     (reset),
      .req_fire  (req_fire[i]),
      .rsp_fire  (rsp_fire[i]),
      .stall     (stall[i]),
      .can_accept(can_acc[i]),
      .pending   (pending[i]),
      .stall_cnt (stall_cnt[i])
    );
  end

  // Round-robin pick: scan from ptr upward, first valid unit wins.
  always_comb begin
    int idx;
    idx            = 0;
    gnt_any        = 1'b0;
    gnt_idx        = '0;
    gnt_data       = '0;
    unit_rsp_ready = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = (int'(ptr) + k) % NUM_UNITS;
      if (!gnt_any && unit_rsp_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = UW'(idx);
        gnt_data = unit_rsp_data[idx];
      end
    end
    if (gnt_any && load && !reset)
      unit_rsp_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      rsp_valid <= gnt_any;
      if (gnt_any) begin
        rsp_data <= gnt_data;
        rsp_sel  <= gnt_idx;
        ptr      <= (gnt_idx == UW'(NUM_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_unit <= 1'b0;
    else if (req_valid && !in_range)
      err_unit <= 1'b1;
  end
endmodule

// File: tb/tb_vx_sfu_router.sv
// Directed bench for vx_sfu_router: a 4-unit instance for the response path and credits,
// a 3-unit MAX_PENDING=2 instance for back-pressure and out-of-range targets.

module tb_vx_sfu_router;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [1:0] sel; logic [63:0] data; } rsp_t;
  rsp_t sb[$];

  // Instance A: NUM_UNITS=4, MAX_PENDING=4
  logic        a_req_valid, a_req_ready;
  logic [1:0]  a_req_unit;
  logic [63:0] a_req_data, a_unit_req_data, a_rsp_data;
  logic [3:0]  a_unit_req_valid, a_unit_req_ready, a_unit_rsp_valid, a_unit_rsp_ready;
  logic [255:0] a_unit_rsp_data;
  logic        a_rsp_valid, a_rsp_ready, a_idle, a_err_unit;
  logic [1:0]  a_rsp_sel;
  logic [11:0] a_pending;
  logic [63:0] a_stall_cnt;

  // Instance B: NUM_UNITS=3, MAX_PENDING=2
  logic        b_req_valid, b_req_ready;
  logic [1:0]  b_req_unit;
  logic [63:0] b_req_data, b_unit_req_data, b_rsp_data;
  logic [2:0]  b_unit_req_valid, b_unit_req_ready, b_unit_rsp_valid, b_unit_rsp_ready;
  logic [191:0] b_unit_rsp_data;
  logic        b_rsp_valid, b_rsp_ready, b_idle, b_err_unit;
  logic [1:0]  b_rsp_sel;
  logic [5:0]  b_pending;
  logic [47:0] b_stall_cnt;

  vx_sfu_router #(.NUM_UNITS(4), .MAX_PENDING(4)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_unit(a_req_unit), .req_data(a_req_data),
    .unit_req_valid(a_unit_req_valid), .unit_req_ready(a_unit_req_ready), .unit_req_data(a_unit_req_data),
    .unit_rsp_valid(a_unit_rsp_valid), .unit_rsp_ready(a_unit_rsp_ready), .unit_rsp_data(a_unit_rsp_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_sel(a_rsp_sel),
    .pending(a_pending), .idle(a_idle), .err_unit(a_err_unit), .stall_cnt(a_stall_cnt)
  );

  vx_sfu_router #(.NUM_UNITS(3), .MAX_PENDING(2)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_unit(b_req_unit), .req_data(b_req_data),
    .unit_req_valid(b_unit_req_valid), .unit_req_ready(b_unit_req_ready), .unit_req_data(b_unit_req_data),
    .unit_rsp_valid(b_unit_rsp_valid), .unit_rsp_ready(b_unit_rsp_ready), .unit_rsp_data(b_unit_rsp_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_sel(b_rsp_sel),
    .pending(b_pending), .idle(b_idle), .err_unit(b_err_unit), .stall_cnt(b_stall_cnt)
  );

  function automatic logic [63:0] udata(input int u);
    return {32'hC0DE0000, 32'(u)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int u);
    rsp_t e;
    e.sel  = 2'(u);
    e.data = udata(u);
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every output handshake pops the oldest expected response.
  always @(negedge clk) begin
    if (!reset && a_rsp_valid && a_rsp_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_sel", 64'(a_rsp_sel), 64'(e.sel));
        chk("rsp_data", a_rsp_data, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b1; a_req_unit = 2'd0; a_req_data = 64'h0;
    a_unit_req_ready = 4'hF; a_unit_rsp_valid = 4'h0; a_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) a_unit_rsp_data[i*64 +: 64] = udata(i);
    b_req_valid = 1'b0; b_req_unit = 2'd0; b_req_data = 64'h0;
    b_unit_req_ready = 3'b000; b_unit_rsp_valid = 3'b000; b_rsp_ready = 1'b1;
    b_unit_rsp_data = '0;

    #3;
    chk("rst_unit_req_valid", 64'(a_unit_req_valid), 64'h0);
    chk("rst_idle", 64'(a_idle), 64'd1);
    chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("rst_pending", 64'(a_pending), 64'h0);
    chk("rst_err_unit", 64'(b_err_unit), 64'd0);
    tick;
    a_req_valid = 1'b0;
    reset = 1'b0;
    tick;

    // Credit limit on B unit 1 (MAX_PENDING=2)
    b_unit_req_ready = 3'b010; b_req_unit = 2'd1; b_req_data = 64'h1234_5678_9ABC_DEF0; b_req_valid = 1'b1;
    @(negedge clk);
    chk("b_req_ready_1", 64'(b_req_ready), 64'd1);
    chk("b_unit_req_valid_1", 64'(b_unit_req_valid), 64'b010);
    chk("b_unit_req_data", b_unit_req_data, 64'h1234_5678_9ABC_DEF0);
    tick;
    chk("b_pending1_1", 64'(b_pending[3:2]), 64'd1);
    @(negedge clk);
    chk("b_req_ready_2", 64'(b_req_ready), 64'd1);
    tick;
    chk("b_pending1_2", 64'(b_pending[3:2]), 64'd2);
    @(negedge clk);
    chk("b_req_ready_full", 64'(b_req_ready), 64'd0);
    chk("b_unit_req_valid_full", 64'(b_unit_req_valid), 64'b000);
    tick;
    chk("b_stall1_1", 64'(b_stall_cnt[31:16]), 64'd1);
    tick;
    chk("b_stall1_2", 64'(b_stall_cnt[31:16]), 64'd2);
    chk("b_pending1_hold", 64'(b_pending[3:2]), 64'd2);
    chk("b_idle_busy", 64'(b_idle), 64'd0);

    // Out-of-range target on the 3-unit instance
    b_req_unit = 2'd3;
    @(negedge clk);
    chk("b_oor_req_ready", 64'(b_req_ready), 64'd1);
    chk("b_oor_unit_req_valid", 64'(b_unit_req_valid), 64'b000);
    tick;
    chk("b_err_set", 64'(b_err_unit), 64'd1);
    chk("b_stall1_oor", 64'(b_stall_cnt[31:16]), 64'd2);
    b_req_valid = 1'b0;
    repeat (3) tick;
    chk("b_err_sticky", 64'(b_err_unit), 64'd1);
    chk("b_pending1_oor", 64'(b_pending[3:2]), 64'd2);

    // Round-robin over units 0,2,3 with continuous rsp_ready
    a_rsp_ready = 1'b1; a_unit_rsp_valid = 4'b1101;
    begin
      int seq [4] = '{0, 2, 3, 0};
      for (int k = 0; k < 4; k++) begin
        push(seq[k]);
        @(negedge clk);
        chk("rr_unit_rsp_ready", 64'(a_unit_rsp_ready), 64'(4'b0001 << seq[k]));
        tick;
      end
    end

    // Output back-pressure
    a_rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_unit_rsp_ready", 64'(a_unit_rsp_ready), 64'h0);
      chk("bp_rsp_valid", 64'(a_rsp_valid), 64'd1);
      chk("bp_rsp_sel", 64'(a_rsp_sel), 64'd0);
      chk("bp_rsp_data", a_rsp_data, udata(0));
      tick;
    end
    a_rsp_ready = 1'b1;
    push(2);
    @(negedge clk);
    chk("rel_unit_rsp_ready", 64'(a_unit_rsp_ready), 64'b0100);
    tick;
    chk("rel_rsp_sel", 64'(a_rsp_sel), 64'd2);
    a_unit_rsp_valid = 4'b0000;
    tick;
    chk("drain_rsp_valid", 64'(a_rsp_valid), 64'd0);

    // Simultaneous request and response fire on unit 0
    a_unit_req_ready = 4'b0001; a_req_unit = 2'd0; a_req_valid = 1'b1;
    tick;
    chk("a_pending0_1", 64'(a_pending[2:0]), 64'd1);
    a_unit_rsp_valid = 4'b0001;
    push(0);
    @(negedge clk);
    chk("sim_unit_req_valid", 64'(a_unit_req_valid), 64'b0001);
    chk("sim_unit_rsp_ready", 64'(a_unit_rsp_ready), 64'b0001);
    tick;
    chk("a_pending0_sim", 64'(a_pending[2:0]), 64'd1);
    a_req_valid = 1'b0; a_unit_rsp_valid = 4'b0000;
    tick;
    chk("sim_rsp_valid_clr", 64'(a_rsp_valid), 64'd0);

    // Reset mid-transaction
    a_unit_req_ready = 4'b0100; a_req_unit = 2'd2; a_req_valid = 1'b1; a_rsp_ready = 1'b0;
    tick;
    tick;
    a_unit_rsp_valid = 4'b0010;
    tick;
    a_unit_rsp_valid = 4'b0000;
    chk("pre_rst_pending2", 64'(a_pending[8:6]), 64'd3);
    chk("pre_rst_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("pre_rst_rsp_sel", 64'(a_rsp_sel), 64'd1);
    chk("pre_rst_idle", 64'(a_idle), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("async_rsp_data", a_rsp_data, 64'h0);
    chk("async_rsp_sel", 64'(a_rsp_sel), 64'd0);
    chk("async_pending", 64'(a_pending), 64'h0);
    chk("async_idle", 64'(a_idle), 64'd1);
    chk("async_unit_req_valid", 64'(a_unit_req_valid), 64'h0);
    chk("async_b_err", 64'(b_err_unit), 64'd0);
    chk("async_b_pending", 64'(b_pending), 64'h0);
    chk("async_b_stall", 64'(b_stall_cnt), 64'h0);
    tick;
    reset = 1'b0;
    a_req_valid = 1'b0;
    tick;
    chk("post_rst_idle", 64'(a_idle), 64'd1);
    chk("post_rst_pending", 64'(a_pending), 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
